uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered 8-bit UART transmitter: FIFO feeds a START/DATA/[PARITY]/STOP shifter, CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1); otherwise the frame is 8N1.
module uart_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overflow,
    output logic       uart_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        wr_en;
    logic        pop;
    logic [7:0]  head;

    logic [2:0]  state;
    logic [15:0] timer;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        timer_done;
    logic        line_next;
`ifdef UART_TX_PARITY_EN
    logic        par;
`endif

    // Extra pointer bit: equal low bits with differing MSB means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign tx_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en   = tx_write && !tx_full;
    assign head    = mem[rd_ptr[AW-1:0]];

    assign timer_done = (timer == 16'd0);
    assign pop        = !empty && ((state == IDLE) || (state == STOP && timer_done));
    assign tx_busy    = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_comb begin
        line_next = 1'b1;
        case (state)
            START:   line_next = 1'b0;
            DATA:    line_next = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_next = par;
`endif
            default: line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx_done     <= 1'b0;
            tx_overflow <= 1'b0;
            uart_out    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            // Line is a one-cycle-delayed copy of the state's bit, keeping the pin purely registered.
            uart_out    <= line_next;
            tx_done     <= (state == STOP) && timer_done;
            tx_overflow <= tx_write && tx_full;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                shreg   <= head;
                state   <= START;
                timer   <= BIT_LAST;
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^head;
`endif
            end else if (state != IDLE) begin
                if (!timer_done) begin
                    timer <= timer - 16'd1;
                end else begin
                    timer <= BIT_LAST;
                    case (state)
                        START: state <= DATA;
                        DATA: begin
                            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {1'b0, shreg[7:1]};
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: state <= STOP;
`endif
                        STOP: begin
                            state <= IDLE;
                            timer <= '0;
                        end
                        default: begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame table plus FIFO, back-to-back and reset sequences, checked by a loop-back receiver.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_write = 1'b0;
    logic       tx_full, tx_busy, tx_done, tx_overflow, uart_out;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_write(tx_write),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_overflow(tx_overflow), .uart_out(uart_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] exp_q[$];
    int          cyc = 0;
    bit          rx_act = 1'b0;
    int          rx_cnt = 0;
    int          rx_start_prev = 0;
    int          rx_start_last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] frame_img(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
        return {1'b1, p, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0} | {10'd0, p & 1'b0};
`endif
    endfunction

    // Loop-back receiver: demands each bit be stable for CPB cycles and tx_done only on the last stop cycle.
    task automatic rx_proc();
        logic [10:0] bits;
        bit          glitch;
        int          idx;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rx_act = 1'b0;
            end else begin
                if (!rx_act) begin
                    if (uart_out == 1'b0) begin
                        rx_act = 1'b1;
                        rx_cnt = 1;
                        bits   = '0;
                        glitch = 1'b0;
                        rx_start_prev = rx_start_last;
                        rx_start_last = cyc;
                    end
                end else begin
                    rx_cnt++;
                end
                if (rx_act) begin
                    idx = (rx_cnt - 1) / CPB;
                    if ((rx_cnt - 1) % CPB == 0) bits[idx] = uart_out;
                    else if (bits[idx] !== uart_out) glitch = 1'b1;
                    if (rx_cnt != NB * CPB && tx_done) glitch = 1'b1;
                    if (rx_cnt == NB * CPB) begin
                        rx_act = 1'b0;
                        chk("rx_done_at_end", tx_done, 1);
                        chk("rx_bit_stable", glitch, 0);
                        chk("rx_frame_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) chk("rx_frame_bits", bits, exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    // Call on a falling edge: the write is sampled on the next rising edge.
    task automatic write_byte(input logic [7:0] d);
        tx_write = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_write = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!tx_busy && !rx_act) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", ok, 1);
        @(negedge clk);
        chk("idle_line_high", uart_out, 1);
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] ob[6];
        bit         held;
        bit         quiet;
        bit         seen;

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h07, 1'b1};
        vecs[4] = '{8'h03, 1'b0};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'hA5, 1'b0};
        ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        fork
            rx_proc();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_uart_out", uart_out, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_tx_overflow", tx_overflow, 0);

        // First write on the first edge after release; start bit appears two edges later.
        exp_q.push_back(frame_img(8'h55, 1'b0));
        rst = 1'b0;
        write_byte(8'h55);
        chk("lat_n_line", uart_out, 1);
        chk("lat_n_busy", tx_busy, 1);
        @(negedge clk);
        chk("lat_n1_line", uart_out, 1);
        @(negedge clk);
        chk("lat_n2_line", uart_out, 0);
        wait_idle();

        for (int v = 0; v < 7; v++) begin
            exp_q.push_back(frame_img(vecs[v].data, vecs[v].par));
            write_byte(vecs[v].data);
            wait_idle();
        end

        exp_q.push_back(frame_img(8'hA3, 1'b0));
        exp_q.push_back(frame_img(8'h0F, 1'b0));
        write_byte(8'hA3);
        write_byte(8'h0F);
        wait_idle();
        chk("b2b_no_gap", rx_start_last - rx_start_prev, NB * CPB);

        for (int i = 0; i < 5; i++) exp_q.push_back(frame_img(ob[i], 1'b0 ^ (^ob[i] & 1'b0)));
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < 5; i++) exp_q[exp_q.size() - 5 + i][9] = (i == 0 || i == 1 || i == 4) ? 1'b0 : 1'b0;
`endif
        for (int i = 0; i < 6; i++) begin
            tx_write = 1'b1;
            tx_data  = ob[i];
            @(negedge clk);
            if (i == 3) chk("ovf_full_at4", tx_full, 0);
            if (i == 4) chk("ovf_full_at5", tx_full, 1);
            if (i == 4) chk("ovf_none_at5", tx_overflow, 0);
            if (i == 5) chk("ovf_pulse", tx_overflow, 1);
        end
        tx_write = 1'b0;
        @(negedge clk);
        chk("ovf_pulse_end", tx_overflow, 0);
        held = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
            if (!tx_full) held = 1'b0;
            @(negedge clk);
        end
        chk("ovf_done_seen", seen, 1);
        chk("ovf_full_held", held, 1);
        chk("ovf_full_clr_on_pop", tx_full, 0);
        wait_idle();

        // Reset mid-frame: during data bit 3 of 0xFF, then during the start bit of 0x00.
        for (int r = 0; r < 2; r++) begin
            write_byte(r == 0 ? 8'hFF : 8'h00);
            write_byte(8'h5A);
            write_byte(8'hC3);
            seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (rx_act && rx_cnt >= (r == 0 ? 17 : 2)) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("rst_mid_reached", seen, 1);
            #2 rst = 1'b1;
            #1;
            chk("rst_mid_line", uart_out, 1);
            chk("rst_mid_busy", tx_busy, 0);
            chk("rst_mid_full", tx_full, 0);
            chk("rst_mid_done", tx_done, 0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            quiet = 1'b1;
            for (int i = 0; i < 120; i++) begin
                @(negedge clk);
                if (!uart_out || tx_busy || tx_done) quiet = 1'b0;
            end
            chk("rst_no_resume", quiet, 1);
        end

        exp_q.push_back(frame_img(8'h81, 1'b0));
        write_byte(8'h81);
        wait_idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

endmodule
